// File: rtl/piso_tx_scheduler_pkg.sv
// Shared types and default widths for the PISO transmit scheduler.
// Optional build macro: PISO_TX_SCHED_TIMEOUT_EN (adds the S_RUN watchdog in the top).
package piso_pkg;

    localparam int SIZE_DATA_IN  = 16;
    localparam int SIZE_DATA_OUT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_REL,
        S_WAIT
    } state_e;

endpackage

// File: rtl/piso_tx_scheduler_if.sv
// Requester-side and serializer-side signals of the scheduler.
// slave = scheduler view, master = producer/serializer environment view.
// Optional build macro: PISO_TX_SCHED_TIMEOUT_EN (adds o_timeout).
interface piso_tx_scheduler_if #(
    parameter int NUM_REQ      = 4,
    parameter int SIZE_DATA_IN = 16
);
    localparam int SIZE_ID = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]              i_req;
    logic [NUM_REQ*SIZE_DATA_IN-1:0] i_req_data;
    logic [NUM_REQ-1:0]              o_ack;
    logic                            o_ser_start;
    logic [SIZE_DATA_IN-1:0]         o_ser_data;
    logic                            i_ser_done;
    logic [SIZE_ID-1:0]              o_grant_id;
    logic                            o_busy;
`ifdef PISO_TX_SCHED_TIMEOUT_EN
    logic                            o_timeout;

    modport slave (
        input  i_req, i_req_data, i_ser_done,
        output o_ack, o_ser_start, o_ser_data, o_grant_id, o_busy, o_timeout
    );
    modport master (
        output i_req, i_req_data, i_ser_done,
        input  o_ack, o_ser_start, o_ser_data, o_grant_id, o_busy, o_timeout
    );
`else
    modport slave (
        input  i_req, i_req_data, i_ser_done,
        output o_ack, o_ser_start, o_ser_data, o_grant_id, o_busy
    );
    modport master (
        output i_req, i_req_data, i_ser_done,
        input  o_ack, o_ser_start, o_ser_data, o_grant_id, o_busy
    );
`endif

endinterface

// File: rtl/piso_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int SIZE_ID = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SIZE_ID-1:0] ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SIZE_ID-1:0] gnt_id_o,
    output logic               any_o
);

    // Scan from the pointer upward; the found flag keeps only the first hit.
    always_comb begin
        logic found;
        int   idx;
        found    = 1'b0;
        idx      = 0;
        gnt_o    = '0;
        gnt_id_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = SIZE_ID'(idx);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one PISO serializer between NUM_REQ requesters.
// One word per grant; data settles a cycle before start rises, start is held
// until done, then a release/wait phase guards against a stale done.
// Optional build macro: PISO_TX_SCHED_TIMEOUT_EN (S_RUN watchdog + o_timeout).
module piso_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int SIZE_DATA_IN = piso_pkg::SIZE_DATA_IN
`ifdef PISO_TX_SCHED_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC  = 32
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    piso_tx_scheduler_if.slave     bus
);
    import piso_pkg::*;

    localparam int SIZE_ID = $clog2(NUM_REQ);

    state_e                  state_q;
    logic [SIZE_ID-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SIZE_ID-1:0]      gid_q;
    logic [SIZE_DATA_IN-1:0] data_q;
    logic [NUM_REQ-1:0]      ack_q;
    logic                    start_q;
    logic                    busy_q;
    logic                    run_end;

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [SIZE_ID-1:0]      arb_id;
    logic                    arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i    (bus.i_req),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (arb_gnt),
        .gnt_id_o (arb_id),
        .any_o    (arb_any)
    );

    // Pointer moves to the slot just after the requester that owned the frame.
    always_comb begin
        rr_ptr_d = (gid_q == SIZE_ID'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
    end

`ifdef PISO_TX_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_hit;
    logic             timeout_q;

    // Watchdog expires on the TIMEOUT_CYC-th S_RUN cycle without done.
    always_comb begin
        tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
        run_end = bus.i_ser_done | tmo_hit;
    end

    // Counter cleared on S_RUN entry, pulse raised only when done never came.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q == S_LOAD) begin
                tmo_cnt_q <= '0;
            end else if (state_q == S_RUN) begin
                if (run_end) timeout_q <= ~bus.i_ser_done;
                else         tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    always_comb begin
        run_end = bus.i_ser_done;
    end
`endif

    // Frame FSM with registered handshake/serializer outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gid_q    <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (arb_any) begin
                        data_q  <= bus.i_req_data[arb_id*SIZE_DATA_IN +: SIZE_DATA_IN];
                        gid_q   <= arb_id;
                        ack_q   <= arb_gnt;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    start_q <= 1'b1;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (run_end) begin
                        start_q <= 1'b0;
                        state_q <= S_REL;
                    end
                end
                S_REL: begin
                    busy_q   <= 1'b0;
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (!bus.i_ser_done) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ack       = ack_q;
    assign bus.o_ser_start = start_q;
    assign bus.o_ser_data  = data_q;
    assign bus.o_grant_id  = gid_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: frame-timeline model, per-cycle compare,
// a serializer responder, and directed scenarios with literal expectations.
module tb_piso_tx_scheduler;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_tx_scheduler_if #(.NUM_REQ(N), .SIZE_DATA_IN(W)) bus();

    piso_tx_scheduler #(.NUM_REQ(N), .SIZE_DATA_IN(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is a timeline anchored at its grant edge.
    //   ack the cycle after the grant edge, start from one edge later until
    //   the first done sampled in the run window, busy through one more cycle,
    //   pointer advances one edge after that, then re-arbitration only after
    //   done has been seen low.
    int          ec = 0, active = 0, g_edge = 0, done_e = -1, arb_from = 0, ptr = 0, mgid = 0, mg;
    logic [W-1:0] mdata = '0;
    int          gq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ec = 0; active = 0; ptr = 0; mgid = 0; mdata = '0;
            arb_from = 0; g_edge = 0; done_e = -1;
        end else begin
            ec++;
            if (active == 0) begin
                if (ec >= arb_from && bus.i_req != '0) begin
                    mg = -1;
                    for (int k = 0; k < N; k++)
                        if (mg < 0 && bus.i_req[(ptr + k) % N]) mg = (ptr + k) % N;
                    active = 1; g_edge = ec; done_e = -1; mgid = mg;
                    mdata = bus.i_req_data[mg*W +: W];
                    gq.push_back(mg);
                end
            end else if (done_e < 0) begin
                if (ec >= g_edge + 2 && bus.i_ser_done) done_e = ec;
            end else if (ec == done_e + 1) begin
                ptr = (mgid + 1) % N;
            end else if (!bus.i_ser_done) begin
                active = 0; arb_from = ec + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        logic [N-1:0] e_ack;
        logic         e_start, e_busy;
        #1;
        e_ack = '0;
        if (active != 0 && ec == g_edge) e_ack[mgid] = 1'b1;
        e_start = (active != 0) && (ec >= g_edge + 1) && (done_e < 0);
        e_busy  = (active != 0) && (done_e < 0 || ec == done_e);
        chk("ack",   32'(bus.o_ack),       32'(e_ack));
        chk("start", 32'(bus.o_ser_start), 32'(e_start));
        chk("busy",  32'(bus.o_busy),      32'(e_busy));
        chk("data",  32'(bus.o_ser_data),  32'(mdata));
        chk("gid",   32'(bus.o_grant_id),  32'(mgid));
    end

    // Serializer stand-in: done after 8 start cycles, optionally held stale.
    int rcnt = 0, hold = 0, stale_cfg = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rcnt = 0; hold = 0; bus.i_ser_done = 1'b0;
        end else if (bus.o_ser_start) begin
            rcnt++;
            if (rcnt >= 8) begin
                bus.i_ser_done = 1'b1;
                hold = stale_cfg;
            end
        end else begin
            rcnt = 0;
            if (hold > 0) hold--;
            else bus.i_ser_done = 1'b0;
        end
    end

    task automatic wait_grants(input int target, input int budget);
        int n = 0;
        while (gq.size() < target && n < budget) begin
            @(posedge clk); #2; n++;
        end
        chk("grant_wait", 32'(gq.size() >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (active != 0 && n < budget) begin
            @(posedge clk); #2; n++;
        end
        chk("idle_wait", 32'(active == 0), 32'd1);
    endtask

    initial begin
        int base, t1, t2, n;
        bus.i_req = '0;
        bus.i_req_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack",   32'(bus.o_ack), 0);
        chk("rst_start", 32'(bus.o_ser_start), 0);
        chk("rst_data",  32'(bus.o_ser_data), 0);
        chk("rst_gid",   32'(bus.o_grant_id), 0);
        chk("rst_busy",  32'(bus.o_busy), 0);
        @(negedge clk) rst_n = 1'b1;

        // Single request on slot 2
        @(negedge clk);
        bus.i_req_data = {16'h4444, 16'hA5C3, 16'h2222, 16'h1111};
        bus.i_req = 4'b0100;
        wait_grants(1, 20);
        chk("t1_ack",   32'(bus.o_ack), 32'h4);
        chk("t1_gid",   32'(bus.o_grant_id), 2);
        chk("t1_data",  32'(bus.o_ser_data), 32'hA5C3);
        chk("t1_start0", 32'(bus.o_ser_start), 0);
        @(negedge clk) bus.i_req = '0;
        @(posedge clk); #2;
        chk("t1_start1", 32'(bus.o_ser_start), 1);
        chk("t1_data1",  32'(bus.o_ser_data), 32'hA5C3);
        wait_idle(40);
        chk("t1_order", 32'(gq[0]), 2);

        // All four continuously requesting, from a fresh pointer
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        base = gq.size();
        bus.i_req_data = {16'hD004, 16'hC003, 16'hB002, 16'hA001};
        bus.i_req = 4'b1111;
        wait_grants(base + 5, 200);
        @(negedge clk) bus.i_req = '0;
        wait_idle(40);
        for (int i = 0; i < 5; i++) chk("t2_order", 32'(gq[base + i]), 32'(i % 4));

        // Pointer wrap: leave pointer at 3, then requests on 0 and 3
        base = gq.size();
        @(negedge clk) bus.i_req = 4'b0100;
        wait_grants(base + 1, 20);
        @(negedge clk) bus.i_req = '0;
        wait_idle(40);
        @(negedge clk) bus.i_req = 4'b1001;
        wait_grants(base + 3, 100);
        @(negedge clk) bus.i_req = '0;
        wait_idle(40);
        chk("t3_first",  32'(gq[base + 1]), 3);
        chk("t3_second", 32'(gq[base + 2]), 0);

        // Stale done held 3 extra cycles: next grant waits for it to drop
        base = gq.size();
        stale_cfg = 3;
        @(negedge clk) bus.i_req = 4'b0001;
        wait_grants(base + 1, 20);
        t1 = g_edge;
        wait_grants(base + 2, 60);
        t2 = g_edge;
        stale_cfg = 0;
        @(negedge clk) bus.i_req = '0;
        wait_idle(60);
        chk("t4_gap",   32'(t2 - t1), 14);
        chk("t4_grant", 32'(gq[base + 1]), 0);

        // Reset during S_RUN
        base = gq.size();
        @(negedge clk) bus.i_req = 4'b0010;
        wait_grants(base + 1, 20);
        n = 0;
        while (!bus.o_ser_start && n < 10) begin @(posedge clk); #2; n++; end
        chk("t5_running", 32'(bus.o_ser_start), 1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_req = 4'b1001;
        #1;
        chk("t5_start", 32'(bus.o_ser_start), 0);
        chk("t5_busy",  32'(bus.o_busy), 0);
        chk("t5_ack",   32'(bus.o_ack), 0);
        chk("t5_gid",   32'(bus.o_grant_id), 0);
        @(negedge clk) rst_n = 1'b1;
        wait_grants(base + 2, 20);
        chk("t5_regrant", 32'(gq[base + 1]), 0);
        @(negedge clk) bus.i_req = '0;
        wait_idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
